// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IF and MEM stage requests share one memory port.
// Data wins by default; a bounded starvation counter lets instruction in.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [15:0] i_address,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_byte_en,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_byte_en,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        m_read,
  output logic        m_write,
  output logic [15:0] m_address,
  output logic [15:0] m_wdata,
  output logic [1:0]  m_byte_en,
  input  logic [15:0] m_rdata,
  input  logic        m_resp,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP
  } state_e;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        gnt_d_q, gnt_d_d;
  logic        op_wr_q, op_wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [2:0]  starve_q, starve_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic i_pend, d_pend, i_win, d_win;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;
  assign i_win  = i_pend & (~d_pend | (starve_q == LIMIT));
  assign d_win  = d_pend & ~i_win;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_d_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      starve_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_d_q   <= gnt_d_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      starve_q  <= starve_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d_d   = gnt_d_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    starve_d  = starve_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d = SERVE_D;
          gnt_d_d = 1'b1;
          op_wr_d = d_write;
          addr_d  = d_address;
          wdata_d = d_wdata;
          be_d    = d_byte_en;
          // Only count grants that actually make the IF port wait.
          if (!i_pend)
            starve_d = '0;
          else if (starve_q != LIMIT)
            starve_d = starve_q + 3'd1;
        end else if (i_win) begin
          state_d  = SERVE_I;
          gnt_d_d  = 1'b0;
          op_wr_d  = i_write;
          addr_d   = i_address;
          wdata_d  = i_wdata;
          be_d     = i_byte_en;
          starve_d = '0;
        end
      end
      SERVE_I: begin
        if (m_resp) begin
          state_d   = RESP;
          i_rdata_d = m_rdata;
        end
      end
      SERVE_D: begin
        if (m_resp) begin
          state_d   = RESP;
          d_rdata_d = m_rdata;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_read    = 1'b0;
    m_write   = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    busy      = (state_q != IDLE);
    m_address = addr_q;
    m_wdata   = wdata_q;
    m_byte_en = be_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    unique case (state_q)
      SERVE_I, SERVE_D: begin
        m_read  = ~op_wr_q;
        m_write = op_wr_q;
      end
      RESP: begin
        i_resp = ~gnt_d_q;
        d_resp = gnt_d_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, collision, starvation,
// abandoned request, stray m_resp and reset mid-transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_read, i_write;
  logic [15:0] i_address, i_wdata;
  logic [1:0]  i_byte_en;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read, d_write;
  logic [15:0] d_address, d_wdata;
  logic [1:0]  d_byte_en;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        m_read, m_write;
  logic [15:0] m_address, m_wdata;
  logic [1:0]  m_byte_en;
  logic [15:0] m_rdata;
  logic        m_resp;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write),
    .i_address(i_address), .i_wdata(i_wdata),
    .i_byte_en(i_byte_en), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write),
    .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_resp(d_resp),
    .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_wdata(m_wdata),
    .m_byte_en(m_byte_en), .m_rdata(m_rdata), .m_resp(m_resp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [15:0] exp_addr [5];
  logic [2:0]  exp_cnt  [5];

  initial begin
    reset_n = 1'b0;
    i_read = 0; i_write = 0; i_address = 0; i_wdata = 0; i_byte_en = 0;
    d_read = 0; d_write = 0; d_address = 0; d_wdata = 0; d_byte_en = 0;
    m_rdata = 0; m_resp = 0;
    cyc(); cyc();
    chk("rst_m_read", 16'(m_read), 16'h0);
    chk("rst_m_write", 16'(m_write), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_i_resp", 16'(i_resp), 16'h0);
    chk("rst_d_resp", 16'(d_resp), 16'h0);
    chk("rst_i_rdata", i_rdata, 16'h0);
    chk("rst_d_rdata", d_rdata, 16'h0);
    chk("rst_m_address", m_address, 16'h0);
    reset_n = 1'b1;

    // Single instruction read
    i_read = 1; i_address = 16'h3000;
    cyc();
    chk("rd_m_read", 16'(m_read), 16'h1);
    chk("rd_m_address", m_address, 16'h3000);
    chk("rd_busy", 16'(busy), 16'h1);
    i_read = 0;
    cyc();
    m_resp = 1; m_rdata = 16'h1234;
    chk("rd_hold", 16'(m_read), 16'h1);
    chk("rd_no_resp_early", 16'(i_resp), 16'h0);
    cyc();
    m_resp = 0;
    chk("rd_i_resp", 16'(i_resp), 16'h1);
    chk("rd_d_resp", 16'(d_resp), 16'h0);
    chk("rd_i_rdata", i_rdata, 16'h1234);
    chk("rd_resp_m_read", 16'(m_read), 16'h0);
    cyc();
    chk("rd_i_resp_once", 16'(i_resp), 16'h0);
    chk("rd_idle_busy", 16'(busy), 16'h0);

    // Collision: data write beats instruction read
    i_read = 1; i_address = 16'h3002;
    d_write = 1; d_address = 16'h4000; d_wdata = 16'hBEEF;
    d_byte_en = 2'b01;
    cyc();
    chk("col_m_write", 16'(m_write), 16'h1);
    chk("col_m_read", 16'(m_read), 16'h0);
    chk("col_m_wdata", m_wdata, 16'hBEEF);
    chk("col_m_byte_en", 16'(m_byte_en), 16'h1);
    chk("col_m_address", m_address, 16'h4000);
    d_write = 0;
    m_resp = 1; m_rdata = 16'h0BAD;
    cyc();
    m_resp = 0;
    chk("col_d_resp", 16'(d_resp), 16'h1);
    chk("col_i_resp_quiet", 16'(i_resp), 16'h0);
    cyc();
    chk("col_idle_busy", 16'(busy), 16'h0);
    chk("col_idle_i_resp", 16'(i_resp), 16'h0);
    cyc();
    chk("col_i_m_read", 16'(m_read), 16'h1);
    chk("col_i_m_address", m_address, 16'h3002);
    i_read = 0;
    m_resp = 1; m_rdata = 16'h5555;
    cyc();
    m_resp = 0;
    chk("col_i_resp", 16'(i_resp), 16'h1);
    chk("col_i_rdata", i_rdata, 16'h5555);
    chk("col_d_resp_quiet", 16'(d_resp), 16'h0);
    cyc();

    // Starvation: D,D,D,D then I
    exp_addr = '{16'h4100, 16'h4100, 16'h4100, 16'h4100, 16'h3004};
    exp_cnt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    i_read = 1; i_address = 16'h3004;
    d_read = 1; d_address = 16'h4100;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("stv_addr_%0d", k), m_address, exp_addr[k]);
      chk($sformatf("stv_cnt_%0d", k), 16'(dut.starve_q), 16'(exp_cnt[k]));
      if (k == 4) begin
        i_read = 0; d_read = 0;
      end
      m_resp = 1; m_rdata = 16'(k);
      cyc();
      m_resp = 0;
      chk($sformatf("stv_i_resp_%0d", k), 16'(i_resp),
          (k == 4) ? 16'h1 : 16'h0);
      chk($sformatf("stv_d_resp_%0d", k), 16'(d_resp),
          (k == 4) ? 16'h0 : 16'h1);
      cyc();
    end

    // Abandoned data read still completes
    d_read = 1; d_address = 16'h4200;
    cyc();
    chk("ab_m_read", 16'(m_read), 16'h1);
    d_read = 0;
    cyc();
    chk("ab_m_read_hold", 16'(m_read), 16'h1);
    chk("ab_m_address", m_address, 16'h4200);
    m_resp = 1; m_rdata = 16'hCAFE;
    cyc();
    m_resp = 0;
    chk("ab_d_resp", 16'(d_resp), 16'h1);
    chk("ab_d_rdata", d_rdata, 16'hCAFE);
    cyc();
    chk("ab_d_resp_once", 16'(d_resp), 16'h0);
    cyc();
    chk("ab_idle", 16'(busy), 16'h0);

    // Stray m_resp in IDLE
    m_resp = 1; m_rdata = 16'hFFFF;
    cyc();
    chk("stray_i_resp", 16'(i_resp), 16'h0);
    chk("stray_d_resp", 16'(d_resp), 16'h0);
    chk("stray_busy", 16'(busy), 16'h0);
    chk("stray_d_rdata", d_rdata, 16'hCAFE);
    m_resp = 0;

    // Reset during SERVE_I
    i_read = 1; i_address = 16'h3006;
    cyc();
    chk("rm_m_read", 16'(m_read), 16'h1);
    i_read = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("rm_m_read_off", 16'(m_read), 16'h0);
    chk("rm_busy", 16'(busy), 16'h0);
    chk("rm_i_rdata", i_rdata, 16'h0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("rm_no_i_resp", 16'(i_resp), 16'h0);
    chk("rm_idle", 16'(busy), 16'h0);
    d_read = 1; d_address = 16'h4300;
    cyc();
    chk("rm_new_addr", m_address, 16'h4300);
    d_read = 0;
    m_resp = 1; m_rdata = 16'h7777;
    cyc();
    m_resp = 0;
    chk("rm_new_d_resp", 16'(d_resp), 16'h1);
    chk("rm_new_d_rdata", d_rdata, 16'h7777);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, meaning: consecutive data grants allowed while an instruction request waits.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_read, i_write  input  1 each  instruction-port request (IF stage).
REQ-005 i_address, i_wdata  input  16 each  instruction-port address and write data.
REQ-006 i_byte_en  input  2  instruction-port byte enables.
REQ-007 i_rdata  output  16  instruction-port read data; i_resp  output  1  instruction-port completion pulse.
REQ-008 d_read, d_write  input  1 each  data-port request (MEM stage).
REQ-009 d_address, d_wdata  input  16 each; d_byte_en  input  2  data-port address, write data and byte enables.
REQ-010 d_rdata  output  16; d_resp  output  1  data-port read data and completion pulse.
REQ-011 m_read, m_write  output  1 each; m_address, m_wdata  output  16 each; m_byte_en  output  2  shared memory command.
REQ-012 m_rdata  input  16; m_resp  input  1  shared memory read data and completion.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SERVE_I, SERVE_D and RESP.
REQ-015 IDLE: a port is pending when its read or write input is high; with no port pending, the FSM stays in IDLE.
REQ-016 Grant priority: data over instruction, except instruction wins when both are pending and starve_cnt == STARVE_LIMIT.
REQ-017 On grant, the winner's address, wdata, byte_en and operation SHALL be registered and the FSM SHALL move to SERVE_I or SERVE_D.
REQ-018 Operation on grant: write when the port's write input is high, else read (write wins if both are high).
REQ-019 SERVE_x: drive m_* from the registered command only, not from live requester inputs.
REQ-020 SERVE_x: m_read = op is read; m_write = op is write.
REQ-021 SERVE_x: hold the command stable until m_resp.
REQ-022 SERVE_x with m_resp high: capture m_rdata into the granted port's rdata register and go to RESP.
REQ-023 RESP: pulse the granted port's x_resp for exactly one cycle, with m_read = m_write = 0, then return to IDLE.
REQ-024 x_rdata SHALL hold its last captured value until the next completion on that port.
REQ-025 Latency: a request first seen in IDLE at cycle N drives m_* at N+1.
REQ-026 With m_resp at cycle N+k (k>=1), x_resp SHALL be high at N+k+1; minimum request-to-resp is 2 cycles.
REQ-027 starve_cnt: 3-bit counter.
REQ-028 starve_cnt increments (saturating at STARVE_LIMIT) on a data grant while the instruction port is pending.
REQ-029 starve_cnt clears on any instruction grant, and on a data grant while the instruction port is idle.
REQ-030 A requester dropping its request mid-transaction SHALL NOT abort it: the memory access completes and x_resp still pulses.
REQ-031 A request that is still asserted in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-032 The non-granted port's x_resp SHALL remain 0 throughout a transaction.
REQ-033 i_resp and d_resp SHALL never be high in the same cycle.
REQ-034 m_resp arriving in IDLE or RESP SHALL be ignored.

Reset
REQ-035 reset_n low SHALL immediately force IDLE, including mid-transaction.
REQ-036 reset_n low SHALL drive m_read, m_write, i_resp, d_resp and busy to 0.
REQ-037 reset_n low SHALL clear starve_cnt, i_rdata, d_rdata, m_address, m_wdata and m_byte_en to 0.
REQ-038 After reset_n rises, the first grant occurs no earlier than the following rising clock edge.

Verification
REQ-039 Single read: i_read=1, i_address=0x3000, m_resp at 2nd SERVE_I cycle with m_rdata=0x1234 -> m_read=1, m_address=0x3000; then i_resp=1 for one cycle, i_rdata=0x1234.
REQ-040 Collision: i_read and d_write (d_address=0x4000, d_wdata=0xBEEF, d_byte_en=2'b01) in the same cycle -> data served first (m_write=1, m_wdata=0xBEEF, m_byte_en=2'b01); instruction served after RESP+IDLE.
REQ-041 Starvation: i_read held, d_read re-asserted every IDLE, STARVE_LIMIT=4 -> grant order D,D,D,D,I; starve_cnt returns to 0 after the I grant.
REQ-042 Abandoned request: d_read dropped one cycle into SERVE_D -> m_read stays high until m_resp; d_resp still pulses once.
REQ-043 Reset mid-transaction: reset_n low during SERVE_I with m_read=1 -> m_read=0, busy=0 and no i_resp; the next request starts from IDLE.
REQ-044 Stray m_resp=1 in IDLE with no requests -> no x_resp pulse; state stays IDLE.
